// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: ID-stage load-use and multi-cycle-unit stall generation,
// plus sequencing of the multi-cycle unit's single write-back slot.
module hazard_scoreboard #(
    parameter int MC_LAT = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ID_Valid_i,
    input  logic [4:0] ID_RsAddr_i,
    input  logic [4:0] ID_RtAddr_i,
    input  logic       ID_UsesRs_i,
    input  logic       ID_UsesRt_i,
    input  logic       ID_RegWrite_i,
    input  logic [4:0] ID_RdAddr_i,
    input  logic       ID_MemRead_i,
    input  logic       ID_MultiCycle_i,
    input  logic       Flush_i,
    output logic       Stall_o,
    output logic       LoadUseStall_o,
    output logic       MCStall_o,
    output logic       MC_Busy_o,
    output logic [4:0] MC_Rd_o,
    output logic       MC_WbEn_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] mc_rd, mc_rd_n, ld_rd;
    logic       mc_wr, mc_wr_n, ld_v, issue, mc_dep;

    always_comb begin
        LoadUseStall_o = ld_v & ID_Valid_i &
                         ((ID_UsesRs_i & (ID_RsAddr_i == ld_rd)) | (ID_UsesRt_i & (ID_RtAddr_i == ld_rd)));
        mc_dep = mc_wr & ((ID_UsesRs_i & (ID_RsAddr_i == mc_rd)) | (ID_UsesRt_i & (ID_RtAddr_i == mc_rd)) |
                          (ID_RegWrite_i & (ID_RdAddr_i == mc_rd)));
        MCStall_o = (state == BUSY) & ID_Valid_i & (ID_MultiCycle_i | mc_dep);
        Stall_o   = LoadUseStall_o | MCStall_o;
        MC_Busy_o = (state == BUSY);
        MC_Rd_o   = mc_rd;
    end

    assign issue = ID_Valid_i & ~Stall_o & ~Flush_i;

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        mc_rd_n   = mc_rd;
        mc_wr_n   = mc_wr;
        MC_WbEn_o = 1'b0;
        if (state == IDLE) begin
            if (issue & ID_MultiCycle_i) begin
                state_n = BUSY;
                cnt_n   = 4'(MC_LAT - 1);
                mc_rd_n = ID_RdAddr_i;
                mc_wr_n = ID_RegWrite_i & (ID_RdAddr_i != 5'd0);
            end
        end else if (cnt != 4'd0) begin
            cnt_n = cnt - 4'd1;
        end else begin
            MC_WbEn_o = mc_wr;
            state_n   = IDLE;
        end
    end

    // A stalled or flushed cycle shifts a bubble into EX, so ld_v drops.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state <= IDLE;
            cnt   <= 4'd0;
            mc_rd <= 5'd0;
            mc_wr <= 1'b0;
            ld_v  <= 1'b0;
            ld_rd <= 5'd0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            mc_rd <= mc_rd_n;
            mc_wr <= mc_wr_n;
            ld_v  <= issue & ID_MemRead_i & ID_RegWrite_i & (ID_RdAddr_i != 5'd0);
            ld_rd <= ID_RdAddr_i;
        end
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed vectors with hand-computed expectations
// for hazard_scoreboard at MC_LAT = 4.
module tb_hazard_scoreboard;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid, uses_rs, uses_rt, reg_write, mem_read, multi, flush;
    logic [4:0] rs, rt, rd;
    logic       stall, lu_stall, mc_stall, busy, wb_en;
    logic [4:0] mc_rd;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(.MC_LAT(4)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .ID_Valid_i(valid), .ID_RsAddr_i(rs), .ID_RtAddr_i(rt),
        .ID_UsesRs_i(uses_rs), .ID_UsesRt_i(uses_rt), .ID_RegWrite_i(reg_write),
        .ID_RdAddr_i(rd), .ID_MemRead_i(mem_read), .ID_MultiCycle_i(multi),
        .Flush_i(flush), .Stall_o(stall), .LoadUseStall_o(lu_stall),
        .MCStall_o(mc_stall), .MC_Busy_o(busy), .MC_Rd_o(mc_rd), .MC_WbEn_o(wb_en)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b, input logic ua,
                         input logic ub, input logic rw, input logic [4:0] d, input logic mr,
                         input logic mc, input logic fl);
        valid = v; rs = a; rt = b; uses_rs = ua; uses_rt = ub;
        reg_write = rw; rd = d; mem_read = mr; multi = mc; flush = fl;
        #3;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic all_zero(input string tag);
        check({tag, "_stall"}, stall, 0);
        check({tag, "_lu"}, lu_stall, 0);
        check({tag, "_mc"}, mc_stall, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_wb"}, wb_en, 0);
        check({tag, "_rd"}, mc_rd, 0);
    endtask

    initial begin
        idle();
        all_zero("por");
        tick();
        rst_n = 1'b1;
        tick();

        // load-use on Rt
        drive(1, 1, 2, 1, 1, 1, 5, 1, 0, 0);
        check("ld_issue_stall", stall, 0);
        tick();
        drive(1, 0, 5, 0, 1, 1, 6, 0, 0, 0);
        check("lu_stall", stall, 1);
        check("lu_cause", lu_stall, 1);
        check("lu_nomc", mc_stall, 0);
        tick();
        check("lu_release", stall, 0);
        tick();
        // load to r0 is never tracked
        drive(1, 1, 2, 1, 1, 1, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 1, 1, 6, 0, 0, 0);
        check("r0_no_stall", stall, 0);
        tick();

        // multi-cycle RAW on Rs
        drive(1, 1, 2, 1, 1, 1, 7, 0, 1, 0);
        check("mul_issue_stall", stall, 0);
        check("mul_issue_busy", busy, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
            check($sformatf("raw_busy%0d", i), busy, 1);
            check($sformatf("raw_stall%0d", i), stall, 1);
            check($sformatf("raw_wb%0d", i), wb_en, i == 3);
            check($sformatf("raw_rd%0d", i), mc_rd, 7);
            tick();
        end
        check("raw_idle", busy, 0);
        check("raw_issue", stall, 0);
        tick();

        // structural: second mul waits for the first
        drive(1, 1, 2, 1, 1, 1, 2, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 1, 1, 1, 1, 9, 0, 1, 0);
            check($sformatf("struct_stall%0d", i), mc_stall, 1);
            tick();
        end
        check("struct_issue", stall, 0);
        tick();
        drive(1, 1, 2, 1, 1, 1, 9, 0, 0, 0);
        check("waw_stall", mc_stall, 1);
        check("waw_rd", mc_rd, 9);
        tick();
        drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 0);
        check("indep_no_stall", stall, 0);
        tick();
        idle();
        tick();
        idle();
        check("struct_wb", wb_en, 1);
        tick();
        check("struct_done", busy, 0);

        // flush on a load and on a mul
        drive(1, 1, 2, 1, 1, 1, 5, 1, 0, 1);
        tick();
        drive(1, 5, 5, 1, 1, 1, 6, 0, 0, 0);
        check("flush_ld_lu", lu_stall, 0);
        check("flush_ld_stall", stall, 0);
        idle();
        drive(1, 1, 2, 1, 1, 1, 7, 0, 1, 1);
        tick();
        idle();
        check("flush_mul_busy", busy, 0);
        // flush during BUSY keeps the write-back
        drive(1, 1, 2, 1, 1, 1, 8, 0, 1, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(1, 1, 2, 1, 1, 1, 3, 0, 0, 1);
            check($sformatf("flush_busy_wb%0d", i), wb_en, i == 3);
            tick();
        end
        idle();
        check("flush_busy_done", busy, 0);

        // coincident load-use and MC hazards
        drive(1, 1, 2, 1, 1, 1, 6, 0, 1, 0);
        tick();
        drive(1, 1, 2, 1, 0, 1, 4, 1, 0, 0);
        check("co_load_issue", stall, 0);
        tick();
        drive(1, 4, 6, 1, 1, 1, 10, 0, 0, 0);
        check("co_lu", lu_stall, 1);
        check("co_mc", mc_stall, 1);
        check("co_stall", stall, 1);
        tick();
        idle();
        tick();
        idle();
        check("co_wb", wb_en, 1);
        tick();

        // asynchronous reset one cycle after a mul issues
        drive(1, 1, 2, 1, 1, 1, 7, 0, 1, 0);
        tick();
        idle();
        check("pre_rst_busy", busy, 1);
        #1 rst_n = 1'b0;
        #1;
        all_zero("async_rst");
        tick();
        tick();
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            #2;
            check($sformatf("post_rst_wb%0d", i), wb_en, 0);
            check($sformatf("post_rst_busy%0d", i), busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
